pixel_stream_broker: RTL and testbench

Parametrised successor to the MCU message broker. It accepts the byte stream delivered by the MCU bus interface and separates command bytes from pixel bytes. Pixel bytes are assembled into pixels of configurable width and buffered in a show-ahead FIFO with a valid/ready handshake toward the RAMDAC pipeline. It sits between the MCU bus interface and the pixel/command consumers, replacing the fixed 12-bit, two-byte, unbuffered assembler.

---
 rtl/message_broker_pkg.sv | 16 +
 rtl/pixel_fifo.sv | 63 ++++++
 rtl/pixel_stream_broker.sv | 158 +++++++++++++++
 tb/tb_pixel_stream_broker.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/message_broker_pkg.sv
// Shared definitions for the pixel stream broker.
// Holds the assembler state enum, MCU byte width and the bytes-per-pixel helper.
package message_broker_pkg;

    localparam int MCU_BYTE_WIDTH = 8;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        COLLECT    = 1'b1
    } asm_state_t;

    function automatic int bytes_per_pixel(input int width);
        return (width + MCU_BYTE_WIDTH - 1) / MCU_BYTE_WIDTH;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always presented on o_dout.
// Ports: i_clk, i_rst (sync, active-high), i_push/i_din, i_pop, o_dout,
//        o_full, o_empty, o_level (occupancy, 0..DEPTH).
module pixel_fifo
    import message_broker_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_dout  = r_mem[r_rd];

    // A full FIFO still takes a push when the head leaves on the same edge.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/pixel_stream_broker.sv
// Splits the MCU byte stream into commands and MSB-first assembled pixels,
// buffering pixels in a show-ahead FIFO with a valid/ready output.
// Ports: system_clock, reset (sync, active-high); byte_valid/byte_data/
//   byte_is_command in; command_valid/command_data out; pixel_valid/
//   pixel_ready/pixel_data handshake; fifo_level, overflow (sticky).
// Macro BROKER_STATS_EN adds saturating drop_count and abort_count ports.
module pixel_stream_broker
    import message_broker_pkg::*;
#(
    parameter int PIXEL_WIDTH = 12,
    parameter int FIFO_DEPTH  = 16,
    parameter int STATS_WIDTH = 16
) (
    input  logic                        system_clock,
    input  logic                        reset,
    input  logic                        byte_valid,
    input  logic [7:0]                  byte_data,
    input  logic                        byte_is_command,
    output logic                        command_valid,
    output logic [7:0]                  command_data,
    output logic                        pixel_valid,
    input  logic                        pixel_ready,
    output logic [PIXEL_WIDTH-1:0]      pixel_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
`ifdef BROKER_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0]      drop_count,
    output logic [STATS_WIDTH-1:0]      abort_count
`endif
);

    localparam int BPP    = bytes_per_pixel(PIXEL_WIDTH);
    localparam int LAST_W = PIXEL_WIDTH - MCU_BYTE_WIDTH * (BPP - 1);
    localparam int IDX_W  = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int ACC_W  = MCU_BYTE_WIDTH * BPP;

    asm_state_t             r_state;
    asm_state_t             w_state_nxt;
    logic [IDX_W-1:0]       r_index;
    logic [IDX_W-1:0]       w_index_nxt;
    logic [ACC_W-1:0]       r_acc;
    logic [ACC_W-1:0]       w_prev;
    logic [PIXEL_WIDTH-1:0] w_pixel;
    logic                   r_cmd_valid;
    logic [7:0]             r_cmd_data;
    logic                   r_overflow;
    logic                   w_pix_byte;
    logic                   w_cmd_byte;
    logic                   w_last;
    logic                   w_done;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push_ok;
    logic                   w_drop;

    assign w_pix_byte = byte_valid & ~byte_is_command;
    assign w_cmd_byte = byte_valid & byte_is_command;
    assign w_last     = (BPP == 1) ||
                        (r_state == COLLECT && r_index == IDX_W'(BPP - 1));
    assign w_done     = w_pix_byte & w_last;

    // Earlier bytes sit above the last byte's low LAST_W bits.
    assign w_prev  = (BPP > 1) ? r_acc : '0;
    assign w_pixel = PIXEL_WIDTH'(w_prev << LAST_W) |
                     PIXEL_WIDTH'(byte_data[LAST_W-1:0]);

    assign w_pop     = pixel_valid & pixel_ready;
    assign w_push_ok = w_done & (~w_full | w_pop);
    assign w_drop    = w_done & ~w_push_ok;

    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        if (w_cmd_byte) begin
            w_state_nxt = WAIT_FIRST;
            w_index_nxt = '0;
        end else if (w_pix_byte) begin
            if (w_last) begin
                w_state_nxt = WAIT_FIRST;
                w_index_nxt = '0;
            end else begin
                w_state_nxt = COLLECT;
                w_index_nxt = r_index + 1'b1;
            end
        end
    end

    always_ff @(posedge system_clock) begin
        if (reset) begin
            r_state     <= WAIT_FIRST;
            r_index     <= '0;
            r_acc       <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_data  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_index     <= w_index_nxt;
            r_cmd_valid <= w_cmd_byte;
            r_overflow  <= r_overflow | w_drop;
            if (w_cmd_byte) begin
                r_cmd_data <= byte_data;
            end
            if (w_pix_byte) begin
                r_acc <= (r_state == WAIT_FIRST) ? ACC_W'(byte_data)
                       : ((r_acc << MCU_BYTE_WIDTH) | ACC_W'(byte_data));
            end
        end
    end

    assign command_valid = r_cmd_valid;
    assign command_data  = r_cmd_data;
    assign overflow      = r_overflow;
    assign pixel_valid   = ~w_empty;

    pixel_fifo #(
        .WIDTH (PIXEL_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (system_clock),
        .i_rst   (reset),
        .i_push  (w_push_ok),
        .i_din   (w_pixel),
        .i_pop   (w_pop),
        .o_dout  (pixel_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

`ifdef BROKER_STATS_EN
    logic [STATS_WIDTH-1:0] r_drop_cnt;
    logic [STATS_WIDTH-1:0] r_abort_cnt;
    logic                   w_abort;

    assign w_abort = w_cmd_byte & (r_state == COLLECT);

    always_ff @(posedge system_clock) begin
        if (reset) begin
            r_drop_cnt  <= '0;
            r_abort_cnt <= '0;
        end else begin
            if (w_drop && r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            if (w_abort && r_abort_cnt != '1) begin
                r_abort_cnt <= r_abort_cnt + 1'b1;
            end
        end
    end

    assign drop_count  = r_drop_cnt;
    assign abort_count = r_abort_cnt;
`endif

endmodule

// File: tb/tb_pixel_stream_broker.sv
// Bench for pixel_stream_broker: three instances (12/24/16-bit pixels, depth 4)
// with per-instance byte strobes and a scoreboard queue of expected pixels.
module tb_pixel_stream_broker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  bd;
    logic        bc;
    logic        bv  [3];
    logic        rdy [3];
    logic        cv  [3];
    logic [7:0]  cd  [3];
    logic        pv  [3];
    logic [2:0]  lvl [3];
    logic        ov  [3];
    logic [11:0] pd12;
    logic [23:0] pd24;
    logic [15:0] pd16;
`ifdef BROKER_STATS_EN
    logic [15:0] dc [3];
    logic [15:0] ac [3];
`endif

    pixel_stream_broker #(.PIXEL_WIDTH(12), .FIFO_DEPTH(4)) u12 (
        .system_clock(clk), .reset(rst), .byte_valid(bv[0]),
        .byte_data(bd), .byte_is_command(bc),
        .command_valid(cv[0]), .command_data(cd[0]),
        .pixel_valid(pv[0]), .pixel_ready(rdy[0]), .pixel_data(pd12),
        .fifo_level(lvl[0]), .overflow(ov[0])
`ifdef BROKER_STATS_EN
        , .drop_count(dc[0]), .abort_count(ac[0])
`endif
    );

    pixel_stream_broker #(.PIXEL_WIDTH(24), .FIFO_DEPTH(4)) u24 (
        .system_clock(clk), .reset(rst), .byte_valid(bv[1]),
        .byte_data(bd), .byte_is_command(bc),
        .command_valid(cv[1]), .command_data(cd[1]),
        .pixel_valid(pv[1]), .pixel_ready(rdy[1]), .pixel_data(pd24),
        .fifo_level(lvl[1]), .overflow(ov[1])
`ifdef BROKER_STATS_EN
        , .drop_count(dc[1]), .abort_count(ac[1])
`endif
    );

    pixel_stream_broker #(.PIXEL_WIDTH(16), .FIFO_DEPTH(4)) u16 (
        .system_clock(clk), .reset(rst), .byte_valid(bv[2]),
        .byte_data(bd), .byte_is_command(bc),
        .command_valid(cv[2]), .command_data(cd[2]),
        .pixel_valid(pv[2]), .pixel_ready(rdy[2]), .pixel_data(pd16),
        .fifo_level(lvl[2]), .overflow(ov[2])
`ifdef BROKER_STATS_EN
        , .drop_count(dc[2]), .abort_count(ac[2])
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] q2[$];

    function automatic logic [31:0] pdata(input int d);
        case (d)
            0:       return 32'(pd12);
            1:       return 32'(pd24);
            default: return 32'(pd16);
        endcase
    endfunction

    task automatic push_exp(input int d, input logic [31:0] v);
        case (d)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    function automatic logic [31:0] pop_exp(input int d);
        logic [31:0] v;
        v = 32'hDEAD_BEEF;
        case (d)
            0:       if (q0.size() > 0) v = q0.pop_front();
            1:       if (q1.size() > 0) v = q1.pop_front();
            default: if (q2.size() > 0) v = q2.pop_front();
        endcase
        return v;
    endfunction

    // Present one byte to instance d for exactly one rising edge.
    task automatic send(input int d, input logic [7:0] b, input logic c);
        bd    = b;
        bc    = c;
        bv[d] = 1'b1;
        @(posedge clk);
        #1;
        bv[d] = 1'b0;
    endtask

    // Wait (bounded) for a pixel, compare with the scoreboard, then pop it.
    task automatic pop_check(input int d, input string nm);
        int n;
        logic [31:0] e;
        n = 0;
        while (!pv[d] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (pv[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: pixel_valid=%0b required 1", nm, pv[d]);
        end else begin
            e = pop_exp(d);
            checks++;
            if (pdata(d) !== e) begin
                errors++;
                $display("FAIL %s: pixel_data=%h required %h", nm, pdata(d), e);
            end
            rdy[d] = 1'b1;
            @(posedge clk);
            #1;
            rdy[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bd  = '0;
        bc  = 1'b0;
        for (int d = 0; d < 3; d++) begin
            bv[d]  = 1'b0;
            rdy[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (pv[d] !== 1'b0 || lvl[d] !== 3'd0 || ov[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_fifo[%0d]: valid=%0b level=%0d ovf=%0b required 0 0 0",
                         d, pv[d], lvl[d], ov[d]);
            end
            checks++;
            if (cv[d] !== 1'b0 || cd[d] !== 8'h00 || pdata(d) !== 32'h0) begin
                errors++;
                $display("FAIL reset_out[%0d]: cmd_valid=%0b cmd=%h pixel=%h required 0 00 0",
                         d, cv[d], cd[d], pdata(d));
            end
`ifdef BROKER_STATS_EN
            checks++;
            if (dc[d] !== 16'd0 || ac[d] !== 16'd0) begin
                errors++;
                $display("FAIL reset_stats[%0d]: drop=%0d abort=%0d required 0 0",
                         d, dc[d], ac[d]);
            end
`endif
        end
        rst = 1'b0;
    endtask

    task automatic test_pixel12();
        send(0, 8'hAB, 1'b0);
        checks++;
        if (pv[0] !== 1'b0) begin
            errors++;
            $display("FAIL p12_partial: pixel_valid=%0b required 0", pv[0]);
        end
        send(0, 8'hCD, 1'b0);
        push_exp(0, 32'hABD);
        checks++;
        if (pv[0] !== 1'b1) begin
            errors++;
            $display("FAIL p12_latency: pixel_valid=%0b required 1", pv[0]);
        end
        pop_check(0, "p12_pixel");
    endtask

    task automatic test_command24();
        send(1, 8'h12, 1'b0);
        send(1, 8'h34, 1'b0);
        send(1, 8'h56, 1'b0);
        push_exp(1, 32'h123456);
        checks++;
        if (pv[1] !== 1'b1 || lvl[1] !== 3'd1) begin
            errors++;
            $display("FAIL p24_push: valid=%0b level=%0d required 1 1", pv[1], lvl[1]);
        end
        send(1, 8'h77, 1'b1);
        checks++;
        if (cv[1] !== 1'b1 || cd[1] !== 8'h77) begin
            errors++;
            $display("FAIL cmd_pulse: cmd_valid=%0b cmd=%h required 1 77", cv[1], cd[1]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cv[1] !== 1'b0 || cd[1] !== 8'h77 || lvl[1] !== 3'd1) begin
            errors++;
            $display("FAIL cmd_single: cmd_valid=%0b cmd=%h level=%0d required 0 77 1",
                     cv[1], cd[1], lvl[1]);
        end
        send(1, 8'h9A, 1'b0);
        send(1, 8'hBC, 1'b0);
        send(1, 8'hDE, 1'b0);
        push_exp(1, 32'h9ABCDE);
        pop_check(1, "p24_first");
        pop_check(1, "p24_after_cmd");
    endtask

    task automatic test_abort16();
        send(2, 8'h11, 1'b0);
        send(2, 8'hC0, 1'b1);
        send(2, 8'h22, 1'b0);
        checks++;
        if (pv[2] !== 1'b0 || cd[2] !== 8'hC0) begin
            errors++;
            $display("FAIL abort_partial: valid=%0b cmd=%h required 0 c0", pv[2], cd[2]);
        end
        send(2, 8'h33, 1'b0);
        push_exp(2, 32'h2233);
        checks++;
        if (lvl[2] !== 3'd1) begin
            errors++;
            $display("FAIL abort_level: level=%0d required 1", lvl[2]);
        end
`ifdef BROKER_STATS_EN
        checks++;
        if (ac[2] !== 16'd1) begin
            errors++;
            $display("FAIL abort_count: got %0d required 1", ac[2]);
        end
`endif
        pop_check(2, "abort_pixel");
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [6];
        seq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        for (int i = 0; i < 6; i++) begin
            send(2, seq[i], 1'b0);
        end
        push_exp(2, 32'hA1B2);
        push_exp(2, 32'hC3D4);
        push_exp(2, 32'hE5F6);
        checks++;
        if (lvl[2] !== 3'd3) begin
            errors++;
            $display("FAIL b2b_level: level=%0d required 3", lvl[2]);
        end
        for (int i = 0; i < 3; i++) begin
            pop_check(2, "b2b_pixel");
        end
    endtask

    task automatic test_overflow();
        rdy[0] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send(0, 8'(i * 16), 1'b0);
            send(0, 8'(i), 1'b0);
            if (i <= 4) push_exp(0, 32'(i * 256 + i));
        end
        checks++;
        if (lvl[0] !== 3'd4 || ov[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_state: level=%0d ovf=%0b required 4 1", lvl[0], ov[0]);
        end
`ifdef BROKER_STATS_EN
        checks++;
        if (dc[0] !== 16'd1) begin
            errors++;
            $display("FAIL drop_count: got %0d required 1", dc[0]);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            pop_check(0, "ovf_drain");
        end
        checks++;
        if (lvl[0] !== 3'd0 || pv[0] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_empty: level=%0d valid=%0b required 0 0", lvl[0], pv[0]);
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] e;
        rdy[1] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send(1, 8'(i), 1'b0);
            send(1, 8'(i + 8'h40), 1'b0);
            if (i == 5) begin
                e = pop_exp(1);
                checks++;
                if (pdata(1) !== e || lvl[1] !== 3'd4) begin
                    errors++;
                    $display("FAIL full_head: pixel=%h level=%0d required %h 4",
                             pdata(1), lvl[1], e);
                end
                rdy[1] = 1'b1;
            end
            send(1, 8'(i + 8'h80), 1'b0);
            rdy[1] = 1'b0;
            push_exp(1, {8'h00, 8'(i), 8'(i + 8'h40), 8'(i + 8'h80)});
        end
        checks++;
        if (lvl[1] !== 3'd4 || ov[1] !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_push: level=%0d ovf=%0b required 4 0", lvl[1], ov[1]);
        end
        for (int i = 0; i < 4; i++) begin
            pop_check(1, "full_drain");
        end
    endtask

    task automatic test_reset_mid();
        send(0, 8'hAB, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (pv[0] !== 1'b0 || lvl[0] !== 3'd0 || ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_fifo: valid=%0b level=%0d ovf=%0b required 0 0 0",
                     pv[0], lvl[0], ov[0]);
        end
        checks++;
        if (cd[1] !== 8'h00 || cd[2] !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_cmd: cmd24=%h cmd16=%h required 00 00", cd[1], cd[2]);
        end
        send(0, 8'hCD, 1'b0);
        checks++;
        if (pv[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_partial: pixel_valid=%0b required 0", pv[0]);
        end
        send(0, 8'hEF, 1'b0);
        push_exp(0, 32'hCDF);
        pop_check(0, "rst_mid_pixel");
    endtask

    initial begin
        test_reset();
        test_pixel12();
        test_command24();
        test_abort16();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
